// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the branch redirect controller
package riscv_pkg;

    localparam int unsigned INSN_BYTES = 4;
    localparam int unsigned XLEN_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redir_state_e;

    // Address fields are sized for the widest supported XLEN; narrower
    // datapaths zero-extend into them.
    typedef struct packed {
        logic                take;
        logic                is_jump;
        logic                pred_taken;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] target;
        logic [XLEN_MAX-1:0] pred_target;
    } branch_res_t;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: detects branch mispredicts, redirects fetch and drains the front end
module branch_redirect_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    input  logic             res_take_i,
    input  logic             res_is_jump_i,
    input  logic             res_pred_taken_i,
    input  logic [XLEN-1:0]  res_pc_i,
    input  logic [XLEN-1:0]  res_target_i,
    input  logic [XLEN-1:0]  res_pred_target_i,
    output logic             redir_valid_o,
    input  logic             redir_ready_i,
    output logic [XLEN-1:0]  redir_pc_o,
    output logic             flush_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    redir_state_e     state_q;
    branch_res_t      res;
    logic             accept;
    logic             actual_taken;
    logic             mispredict;
    logic [XLEN-1:0]  correct_pc;
    logic [XLEN-1:0]  redir_pc_q;
    logic [3:0]       drain_q;
    logic             redir_valid_q;
    logic             flush_q;
    logic             stall_q;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    assign res = '{
        take:        res_take_i,
        is_jump:     res_is_jump_i,
        pred_taken:  res_pred_taken_i,
        pc:          XLEN_MAX'(res_pc_i),
        target:      XLEN_MAX'(res_target_i),
        pred_target: XLEN_MAX'(res_pred_target_i)
    };

    assign res_ready_o  = (state_q == IDLE);
    assign accept       = res_valid_i & res_ready_o;
    assign actual_taken = res.is_jump | res.take;
    assign mispredict   = (actual_taken != res.pred_taken) | (actual_taken & (res.target != res.pred_target));
    // Truncating after the add gives the modulo-2^XLEN wrap of pc+4.
    assign correct_pc   = XLEN'(actual_taken ? res.target : res.pc + XLEN_MAX'(INSN_BYTES));

    // Saturating statistics counters.
    always_comb begin
        branch_cnt_d     = (accept && !(&branch_cnt_q)) ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
        mispredict_cnt_d = (accept && mispredict && !(&mispredict_cnt_q)) ? mispredict_cnt_q + CNT_W'(1) : mispredict_cnt_q;
    end

    // Statistics counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Redirect FSM with registered redirect/flush/stall outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            redir_pc_q    <= '0;
            drain_q       <= '0;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && mispredict) begin
                        state_q       <= REDIRECT;
                        redir_pc_q    <= correct_pc;
                        redir_valid_q <= 1'b1;
                        flush_q       <= 1'b1;
                        stall_q       <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir_ready_i) begin
                        redir_valid_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_q <= IDLE;
                            flush_q <= 1'b0;
                            stall_q <= 1'b0;
                        end else begin
                            state_q <= DRAIN;
                            drain_q <= 4'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == 4'd0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        stall_q <= 1'b0;
                    end else begin
                        drain_q <= drain_q - 4'd1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    redir_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase
        end
    end

    assign redir_valid_o    = redir_valid_q;
    assign redir_pc_o       = redir_pc_q;
    assign flush_o          = flush_q;
    assign stall_o          = stall_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: model-checked bench for a default instance and a FLUSH_CYCLES=0/CNT_W=2 instance
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_take = 1'b0;
    logic        res_is_jump = 1'b0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pc = '0;
    logic [31:0] res_target = '0;
    logic [31:0] res_pred_target = '0;
    logic        redir_ready = 1'b0;

    logic        rdy_a, rv_a, fl_a, st_a;
    logic [31:0] pc_a;
    logic [15:0] bc_a, mc_a;
    logic        rdy_b, rv_b, fl_b, st_b;
    logic [31:0] pc_b;
    logic [1:0]  bc_b, mc_b;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .res_valid_i(res_valid), .res_ready_o(rdy_a),
        .res_take_i(res_take), .res_is_jump_i(res_is_jump), .res_pred_taken_i(res_pred_taken),
        .res_pc_i(res_pc), .res_target_i(res_target), .res_pred_target_i(res_pred_target),
        .redir_valid_o(rv_a), .redir_ready_i(redir_ready), .redir_pc_o(pc_a),
        .flush_o(fl_a), .stall_o(st_a), .branch_cnt_o(bc_a), .mispredict_cnt_o(mc_a));

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .res_valid_i(res_valid), .res_ready_o(rdy_b),
        .res_take_i(res_take), .res_is_jump_i(res_is_jump), .res_pred_taken_i(res_pred_taken),
        .res_pc_i(res_pc), .res_target_i(res_target), .res_pred_target_i(res_pred_target),
        .redir_valid_o(rv_b), .redir_ready_i(redir_ready), .redir_pc_o(pc_b),
        .flush_o(fl_b), .stall_o(st_b), .branch_cnt_o(bc_b), .mispredict_cnt_o(mc_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Abstract model: a pending redirect, a count of flush cycles still owed, and counters.
    int          fc[2] = '{2, 0};
    int          mx[2] = '{65535, 3};
    bit          m_rv[2];
    int          m_fl[2];
    logic [31:0] m_pc[2];
    int          m_bc[2];
    int          m_mc[2];
    bit          m_taken, m_mis;
    logic [31:0] m_cpc;

    always @(posedge clk) begin
        m_taken = res_is_jump | res_take;
        m_cpc   = m_taken ? res_target : res_pc + 32'd4;
        m_mis   = (m_taken != res_pred_taken) || (m_taken && res_target != res_pred_target);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_rv[i] = 0; m_fl[i] = 0; m_pc[i] = '0; m_bc[i] = 0; m_mc[i] = 0;
            end else if (m_rv[i]) begin
                if (redir_ready) begin
                    m_rv[i] = 0;
                    m_fl[i] = fc[i];
                end
            end else if (m_fl[i] > 0) begin
                m_fl[i]--;
            end else if (res_valid) begin
                if (m_bc[i] < mx[i]) m_bc[i]++;
                if (m_mis) begin
                    if (m_mc[i] < mx[i]) m_mc[i]++;
                    m_rv[i] = 1;
                    m_pc[i] = m_cpc;
                end
            end
        end
        #1;
        if (chk_en) begin
            chk("A.redir_valid", 64'(rv_a), 64'(m_rv[0]));
            chk("A.flush", 64'(fl_a), 64'(m_rv[0] || m_fl[0] > 0));
            chk("A.stall", 64'(st_a), 64'(m_rv[0] || m_fl[0] > 0));
            chk("A.ready", 64'(rdy_a), 64'(!(m_rv[0] || m_fl[0] > 0)));
            chk("A.redir_pc", 64'(pc_a), 64'(m_pc[0]));
            chk("A.branch_cnt", 64'(bc_a), 64'(m_bc[0]));
            chk("A.mispredict_cnt", 64'(mc_a), 64'(m_mc[0]));
            chk("B.redir_valid", 64'(rv_b), 64'(m_rv[1]));
            chk("B.flush", 64'(fl_b), 64'(m_rv[1] || m_fl[1] > 0));
            chk("B.stall", 64'(st_b), 64'(m_rv[1] || m_fl[1] > 0));
            chk("B.ready", 64'(rdy_b), 64'(!(m_rv[1] || m_fl[1] > 0)));
            chk("B.redir_pc", 64'(pc_b), 64'(m_pc[1]));
            chk("B.branch_cnt", 64'(bc_b), 64'(m_bc[1]));
            chk("B.mispredict_cnt", 64'(mc_b), 64'(m_mc[1]));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit t, input bit j, input bit p,
                         input logic [31:0] pc, input logic [31:0] tg, input logic [31:0] ptg);
        res_valid = v; res_take = t; res_is_jump = j; res_pred_taken = p;
        res_pc = pc; res_target = tg; res_pred_target = ptg;
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset.ready_a", 64'(rdy_a), 64'd1);
        chk("reset.bc_a", 64'(bc_a), 64'd0);

        // Correctly predicted not-taken BNE
        drive(1, 0, 0, 0, 32'h100, 32'h180, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("nt.redir_a", 64'(rv_a), 64'd0);
        chk("nt.flush_a", 64'(fl_a), 64'd0);
        chk("nt.bc_a", 64'(bc_a), 64'd1);
        chk("nt.mc_a", 64'(mc_a), 64'd0);

        // Direction miss with fetch back-pressure
        drive(1, 1, 0, 0, 32'h104, 32'h200, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("dir.redir_a", 64'(rv_a), 64'd1);
        chk("dir.pc_a", 64'(pc_a), 64'h200);
        chk("dir.flush_a", 64'(fl_a), 64'd1);
        tick();
        chk("dir.hold1_pc_a", 64'(pc_a), 64'h200);
        tick();
        chk("dir.hold2_pc_a", 64'(pc_a), 64'h200);
        chk("dir.hold2_redir_a", 64'(rv_a), 64'd1);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("dir.drain1_flush_a", 64'(fl_a), 64'd1);
        chk("dir.drain1_redir_a", 64'(rv_a), 64'd0);
        chk("dir.nodrain_ready_b", 64'(rdy_b), 64'd1);
        chk("dir.nodrain_flush_b", 64'(fl_b), 64'd0);
        tick();
        chk("dir.drain2_flush_a", 64'(fl_a), 64'd1);
        chk("dir.drain2_ready_a", 64'(rdy_a), 64'd0);
        tick();
        chk("dir.idle_flush_a", 64'(fl_a), 64'd0);
        chk("dir.idle_ready_a", 64'(rdy_a), 64'd1);

        // Reset while a redirect is pending
        drive(1, 1, 0, 0, 32'h108, 32'h240, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("rstr.pre_redir_a", 64'(rv_a), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstr.redir_a", 64'(rv_a), 64'd0);
        chk("rstr.flush_a", 64'(fl_a), 64'd0);
        chk("rstr.bc_a", 64'(bc_a), 64'd0);
        chk("rstr.mc_a", 64'(mc_a), 64'd0);
        chk("rstr.ready_a", 64'(rdy_a), 64'd1);

        // Jump with wrong predicted target
        drive(1, 0, 1, 1, 32'h10c, 32'h300, 32'h304);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("jmp.redir_a", 64'(rv_a), 64'd1);
        chk("jmp.pc_a", 64'(pc_a), 64'h300);
        chk("jmp.mc_a", 64'(mc_a), 64'd1);
        chk("jmp.pc_b", 64'(pc_b), 64'h300);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        tick(2);
        chk("jmp.ready_a", 64'(rdy_a), 64'd1);

        // Predicted taken, actually not taken at the top of the address space
        drive(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h500, 32'h500);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("wrap.redir_a", 64'(rv_a), 64'd1);
        chk("wrap.pc_a", 64'(pc_a), 64'h0);
        chk("wrap.mc_a", 64'(mc_a), 64'd2);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        tick(2);

        // Saturation of the narrow counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 32'h400, 32'h0, 32'h0);
        tick(5);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("sat.bc_b", 64'(bc_b), 64'd3);
        chk("sat.bc_a", 64'(bc_a), 64'd5);
        chk("sat.mc_b", 64'(mc_b), 64'd0);

        // Mispredict held valid while busy; only re-accepted once idle
        drive(1, 1, 0, 0, 32'h600, 32'h700, 32'h0);
        for (int c = 0; c < 12; c++) begin
            redir_ready = (c % 3 == 2);
            tick();
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        redir_ready = 1'b0;
        tick(4);

        // Mixed traffic checked by the model
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, {$urandom_range(0, 255), 2'b00},
                  $urandom_range(0, 1) ? 32'h800 : 32'h804,
                  $urandom_range(0, 3) != 0 ? 32'h800 : 32'h804);
            redir_ready = $urandom_range(0, 2) == 0;
            rst = $urandom_range(0, 60) == 0;
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width.
REQ-002 Parameter FLUSH_CYCLES, default 2, post-redirect drain length in cycles, legal range 0..15.
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 One clock; reset is synchronous and active-high: ports clk_i, rst_i.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 res_valid_i  in  1  resolved control-flow instruction present.
REQ-008 res_ready_o  out  1  controller accepts a resolution this cycle.
REQ-009 res_take_i  in  1  condition outcome from BranchUnit (br_o.take).
REQ-010 res_is_jump_i  in  1  unconditional jump (JAL/JALR); forces taken.
REQ-011 res_pred_taken_i  in  1  fetch-stage predicted direction.
REQ-012 res_pc_i  in  XLEN  PC of the resolved instruction.
REQ-013 res_target_i  in  XLEN  computed taken target.
REQ-014 res_pred_target_i  in  XLEN  fetch-stage predicted target.
REQ-015 redir_valid_o  out  1  redirect request to fetch.
REQ-016 redir_ready_i  in  1  fetch accepts redirect.
REQ-017 redir_pc_o  out  XLEN  corrected fetch PC.
REQ-018 flush_o  out  1  kill younger IF/ID instructions.
REQ-019 stall_o  out  1  hold issue; high whenever state is not IDLE.
REQ-020 branch_cnt_o  out  CNT_W  accepted resolutions count.
REQ-021 mispredict_cnt_o  out  CNT_W  mispredicted resolutions count.

Function
REQ-022 FSM states IDLE, REDIRECT, DRAIN; res_ready_o SHALL be 1 only in IDLE.
REQ-023 Accept = res_valid_i & res_ready_o; inputs sampled only on accept.
REQ-024 actual_taken = res_is_jump_i | res_take_i.
REQ-025 correct_pc = actual_taken ? res_target_i : res_pc_i + 4, addition modulo 2^XLEN (wraps).
REQ-026 mispredict = (actual_taken != res_pred_taken_i) | (actual_taken & res_target_i != res_pred_target_i).
REQ-027 Accept without mispredict: stay IDLE, no redirect, no flush.
REQ-028 Accept with mispredict: register correct_pc into redir_pc_o, next state REDIRECT (one-cycle latency from accept to redir_valid_o).
REQ-029 REDIRECT: redir_valid_o=1, flush_o=1; redir_pc_o stable until redir_ready_i sampled high.
REQ-030 REDIRECT & redir_ready_i: next state DRAIN with drain counter loaded FLUSH_CYCLES-1, or IDLE if FLUSH_CYCLES==0.
REQ-031 DRAIN: flush_o=1, redir_valid_o=0; counter decrements each cycle; at 0 next state IDLE.
REQ-032 res_valid_i during REDIRECT/DRAIN SHALL be ignored (not accepted, not counted); upstream holds it.
REQ-033 branch_cnt_o increments on every accept; mispredict_cnt_o on every mispredicted accept; both saturate at all-ones.
REQ-034 redir_valid_o never deasserts without handshake except on rst_i.

Reset
REQ-035 rst_i SHALL force IDLE; redir_valid_o, flush_o, stall_o, redir_pc_o, both counters, drain counter to 0.
REQ-036 rst_i mid-REDIRECT or mid-DRAIN SHALL abandon the redirect; next cycle res_ready_o=1.
REQ-037 rst_i has priority over a simultaneous accept or redirect handshake.

Structure
REQ-038 State enum redir_state_e and a resolution struct branch_res_t (fields of REQ-009..014) SHALL live in riscv_pkg.
REQ-039 INSN_BYTES=4 constant SHALL live in riscv_pkg.
REQ-040 Single module, no sub-modules; mispredict/correct_pc logic combinational, FSM and counters registered.

Verification
REQ-041 Correct not-taken: BNE take=0, pred=0, pc=0x100 -> no redir, flush_o=0, branch_cnt=1, mispredict_cnt=0.
REQ-042 Direction miss: BEQ take=1, pred=0, target=0x200 -> next cycle redir_valid_o=1, redir_pc_o=0x200, flush_o=1; redir_ready_i held 0 for 3 cycles keeps pc stable; after handshake flush_o high exactly 2 more cycles, then res_ready_o=1.
REQ-043 Target miss on jump: is_jump=1, pred=1, target=0x300, pred_target=0x304 -> redirect to 0x300, mispredict_cnt=1.
REQ-044 Wrap: take=0, pred=1, pc=0xFFFFFFFC -> redir_pc_o=0x00000000.
REQ-045 Reset during REDIRECT -> next cycle redir_valid_o=0, flush_o=0, counters 0, res_ready_o=1.
REQ-046 FLUSH_CYCLES=0 and counter saturation (CNT_W=2, 5 accepts) -> IDLE right after handshake; branch_cnt_o=3.
